// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - Control-bundle bit positions: {regwrite, memwrite, memtoreg, lui, jal}.
//   - Access FSM state encoding.
//   - EX/MEM register layout.
//   - Helper that computes the MEM forwarding value.
package mem_stage_pkg;

  localparam int CTRL_W      = 5;
  localparam int CTRL_REGW   = 4;
  localparam int CTRL_MEMW   = 3;
  localparam int CTRL_MEMR   = 2;  // memtoreg: this is a load
  localparam int CTRL_LUI    = 1;
  localparam int CTRL_JAL    = 0;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fsm_state_e;

  // Only the low immediate half is kept: lui is the sole consumer.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       alu;
    logic [31:0]       din;
    logic [31:0]       pc;
    logic [15:0]       imm_lo;
    logic [4:0]        dst;
  } ex_mem_t;

  // jal takes priority over lui; pc+4 wraps naturally in 32 bits.
  function automatic logic [31:0] fwd_value(input ex_mem_t r);
    if (r.ctrl[CTRL_JAL])      return r.pc + 32'd4;
    else if (r.ctrl[CTRL_LUI]) return {r.imm_lo, 16'h0000};
    else                       return r.alu;
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer for the MEM stage.
//   Inputs : clk, rst_n (sync, active-low), halt (freeze), flush (cancel),
//            access (MEM holds a load/store), misalign (addr[1:0]!=0),
//            dmem_ack (bus done).
//   Outputs: req (bus request), stall (req & ~ack), fault (1-cycle pulse on
//            timeout or misalignment), kill (instruction cancelled while
//            its bus access was outstanding).
// The wait counter holds the number of stall cycles already spent on the
// current access, so a timeout leaves exactly TIMEOUT stall cycles behind it.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt,
  input  logic flush,
  input  logic access,
  input  logic misalign,
  input  logic dmem_ack,
  output logic req,
  output logic stall,
  output logic fault,
  output logic kill
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fsm_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             kill_q, kill_nxt;
  logic             timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kill_q <= 1'b0;
    end else if (!halt) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      kill_q <= kill_nxt;
    end
  end

  assign timeout = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kill_nxt  = kill_q;
    req       = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: begin
        req     = access & ~misalign;
        fault   = access & misalign & ~halt;
        cnt_nxt = '0;
        if (req && !dmem_ack) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(1);
          kill_nxt  = flush;
        end
      end
      S_WAIT: begin
        // Request drops in the timeout cycle; a late ack is ignored.
        req   = ~timeout;
        fault = timeout & ~halt;
        if (timeout || dmem_ack) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          kill_nxt  = 1'b0;
        end else begin
          cnt_nxt  = cnt + CNT_W'(1);
          kill_nxt = kill_q | flush;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall = req & ~dmem_ack;
  assign kill  = kill_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory access, MEM/WB register.
//   clk, rst_n            : clock, synchronous active-low reset
//   halt, flush           : global freeze, cancel of entering/occupying instr
//   ex_*                  : EX-stage bundle (ctrl, alu, store data, pc, imm, dst)
//   mem_ctrl/fwd/dst      : MEM-stage forwarding view
//   dmem_*                : data-memory bus (req held until ack)
//   mem_stall, mem_fault  : upstream freeze, fault pulse
//   fault_pc              : PC of last faulting instruction
//   wb_*                  : MEM/WB bundle
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [31:0]       ex_alu,
  input  logic [31:0]       ex_din,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_imm,
  input  logic [4:0]        ex_dst,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [31:0]       mem_fwd,
  output logic [4:0]        mem_dst,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic [31:0]       fault_pc,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [31:0]       wb_res,
  output logic [31:0]       wb_ram,
  output logic [4:0]        wb_dst
);

  ex_mem_t mem_q, ex_in;
  logic    access, misalign, kill, cancel;
  logic    unused_imm;

  assign unused_imm = ^ex_imm[31:16];

  assign ex_in = '{ctrl:   flush ? '0 : ex_ctrl,
                   alu:    ex_alu,
                   din:    ex_din,
                   pc:     ex_pc,
                   imm_lo: ex_imm[15:0],
                   dst:    ex_dst};

  // EX/MEM: held while stalled; a flush lets a bubble in.
  always_ff @(posedge clk) begin
    if (!rst_n)                  mem_q <= '0;
    else if (!halt && !mem_stall) mem_q <= ex_in;
  end

  assign access   = mem_q.ctrl[CTRL_MEMW] | mem_q.ctrl[CTRL_MEMR];
  assign misalign = |mem_q.alu[1:0];

  mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .halt     (halt),
    .flush    (flush),
    .access   (access),
    .misalign (misalign),
    .dmem_ack (dmem_ack),
    .req      (dmem_req),
    .stall    (mem_stall),
    .fault    (mem_fault),
    .kill     (kill)
  );

  assign mem_ctrl   = mem_q.ctrl;
  assign mem_dst    = mem_q.dst;
  assign mem_fwd    = fwd_value(mem_q);
  assign dmem_we    = mem_q.ctrl[CTRL_MEMW];
  assign dmem_addr  = mem_q.alu[ADDR_W+1:2];
  assign dmem_wdata = mem_q.din;

  // Killed, flushed or faulted instructions retire as WB bubbles.
  assign cancel = flush | kill | mem_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ctrl  <= '0;
      wb_res   <= '0;
      wb_ram   <= '0;
      wb_dst   <= '0;
      fault_pc <= '0;
    end else if (!halt) begin
      if (!mem_stall) begin
        wb_ctrl <= cancel ? '0 : mem_q.ctrl;
        wb_res  <= mem_fwd;
        wb_dst  <= mem_q.dst;
      end
      if (dmem_req && dmem_ack && !dmem_we) wb_ram <= dmem_rdata;
      if (mem_fault) fault_pc <= mem_q.pc;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int AW = 10;
  localparam int TO = 4;

  localparam logic [4:0] C_ALU = 5'b10000;
  localparam logic [4:0] C_LUI = 5'b10010;
  localparam logic [4:0] C_JAL = 5'b10001;
  localparam logic [4:0] C_LD  = 5'b10100;
  localparam logic [4:0] C_ST  = 5'b01000;

  logic          clk = 0, rst_n = 0, halt = 0, flush = 0;
  logic [4:0]    ex_ctrl = 0, ex_dst = 0;
  logic [31:0]   ex_alu = 0, ex_din = 0, ex_pc = 0, ex_imm = 0;
  logic [4:0]    mem_ctrl, mem_dst, wb_ctrl, wb_dst;
  logic [31:0]   mem_fwd, dmem_wdata, fault_pc, wb_res, wb_ram;
  logic          dmem_req, dmem_we, mem_stall, mem_fault;
  logic [AW-1:0] dmem_addr;
  logic          dmem_ack = 0;
  logic [31:0]   dmem_rdata = 0;

  int tests = 0, fails = 0;

  mem_stage #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
    .ex_ctrl(ex_ctrl), .ex_alu(ex_alu), .ex_din(ex_din), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_dst(ex_dst),
    .mem_ctrl(mem_ctrl), .mem_fwd(mem_fwd), .mem_dst(mem_dst),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .fault_pc(fault_pc),
    .wb_ctrl(wb_ctrl), .wb_res(wb_res), .wb_ram(wb_ram), .wb_dst(wb_dst)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ex(input logic [4:0] c, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic [31:0] i, input logic [4:0] r);
    ex_ctrl = c; ex_alu = a; ex_din = d; ex_pc = p; ex_imm = i; ex_dst = r;
  endtask

  task automatic bubble_ex();
    set_ex(5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  // Run until the access in MEM faults; returns stall cycles seen first.
  task automatic run_to_fault(output int n, output bit seen);
    bit f;
    n = 0; seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_stall) n++;
      f = mem_fault;
      step();
      if (f) begin seen = 1; break; end
    end
  endtask

  // ---------------- table of single-cycle instructions ----------------
  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] alu, pc, imm;
    logic [4:0]  dst;
    logic [31:0] exp_fwd;
  } vec_t;
  vec_t vecs[6];

  // ---------------- random-phase reference model ----------------
  typedef struct {
    logic [4:0]  ctrl, dst, exp_wbctrl;
    logic [31:0] alu, din, pc, imm, exp_res, exp_ram;
    int          lat, exp_stall;
    bit          exp_fault;
  } rinstr_t;

  logic [31:0] model_mem [8];
  logic [31:0] resp_mem [1024];
  logic [31:0] last_ram;

  function automatic rinstr_t gen_instr();
    rinstr_t r;
    logic [31:0] tmp;
    logic [2:0]  idx;
    bit mem, mis, ok;
    case ($urandom_range(0, 5))
      0: r.ctrl = C_ALU;
      1: r.ctrl = C_LUI;
      2: r.ctrl = C_JAL;
      3: r.ctrl = C_LD;
      4: r.ctrl = C_ST;
      default: r.ctrl = 5'b0;
    endcase
    r.pc  = $urandom & 32'hFFFF_FFFC;
    r.imm = $urandom;
    r.din = $urandom;
    r.dst = 5'($urandom_range(0, 31));
    r.lat = $urandom_range(0, TO + 1);
    mem   = r.ctrl[3] | r.ctrl[2];
    idx   = 3'($urandom_range(0, 7));
    tmp   = $urandom;
    if (mem) r.alu = {tmp[31:12], 7'd0, idx, 2'b00};
    else     r.alu = tmp;
    mis = mem && ($urandom_range(0, 7) == 0);
    if (mis) r.alu[1:0] = 2'($urandom_range(1, 3));
    ok = mem && !mis && (r.lat < TO);
    r.exp_fault  = mem && !ok;
    r.exp_stall  = (!mem || mis) ? 0 : ((r.lat < TO) ? r.lat : TO);
    r.exp_wbctrl = r.exp_fault ? 5'b0 : r.ctrl;
    if (r.ctrl[0])      r.exp_res = r.pc + 32'd4;
    else if (r.ctrl[1]) r.exp_res = {r.imm[15:0], 16'h0};
    else                r.exp_res = r.alu;
    if (ok && r.ctrl[3]) model_mem[idx] = r.din;
    if (ok && r.ctrl[2]) last_ram = model_mem[idx];
    r.exp_ram = last_ram;
    return r;
  endfunction

  initial begin
    int  n;
    bit  seen, st;
    rinstr_t cur, nxt;
    int  waited, stalls, faults;

    vecs[0] = '{C_ALU,   32'h0000_1234, 32'h0000_0100, 32'h0,          5'd5,  32'h0000_1234};
    vecs[1] = '{C_LUI,   32'h0000_0005, 32'h0,         32'hABCD_1234,  5'd7,  32'h1234_0000};
    vecs[2] = '{C_JAL,   32'h0000_0009, 32'hFFFF_FFFC, 32'h0,          5'd31, 32'h0000_0000};
    vecs[3] = '{C_JAL,   32'h0,         32'h0040_0010, 32'h0,          5'd31, 32'h0040_0014};
    vecs[4] = '{5'b0,    32'h0000_0077, 32'h0,         32'h0,          5'd0,  32'h0000_0077};
    vecs[5] = '{5'b10011, 32'h1,        32'h0000_0020, 32'hFFFF_0000,  5'd1,  32'h0000_0024};

    // reset state
    do_reset();
    chk("rst mem_ctrl", mem_ctrl, 0);
    chk("rst wb_ctrl", wb_ctrl, 0);
    chk("rst wb_res", wb_res, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst mem_stall", mem_stall, 0);
    chk("rst fault_pc", fault_pc, 0);

    // non-memory instructions: forwarding value and WB bundle
    foreach (vecs[i]) begin
      set_ex(vecs[i].ctrl, vecs[i].alu, 32'h0, vecs[i].pc, vecs[i].imm, vecs[i].dst);
      step();
      bubble_ex();
      @(negedge clk);
      chk("vec mem_fwd", mem_fwd, vecs[i].exp_fwd);
      chk("vec mem_ctrl", mem_ctrl, vecs[i].ctrl);
      chk("vec mem_dst", mem_dst, vecs[i].dst);
      chk("vec dmem_req", dmem_req, 0);
      step();
      chk("vec wb_res", wb_res, vecs[i].exp_fwd);
      chk("vec wb_dst", wb_dst, vecs[i].dst);
      chk("vec wb_ctrl", wb_ctrl, vecs[i].ctrl);
    end

    // zero-wait load
    set_ex(C_LD, 32'h40, 32'h0, 32'h1000, 32'h0, 5'd3); step(); bubble_ex();
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("zw req", dmem_req, 1);
    chk("zw addr", dmem_addr, 32'h10);
    chk("zw stall", mem_stall, 0);
    chk("zw we", dmem_we, 0);
    step(); dmem_ack = 0;
    chk("zw wb_ram", wb_ram, 32'hDEAD_BEEF);
    chk("zw wb_ctrl", wb_ctrl, C_LD);

    // store with 3 wait cycles, EX/MEM held
    set_ex(C_ST, 32'h80, 32'h55, 32'h2000, 32'h0, 5'd0); step();
    set_ex(C_ALU, 32'h777, 32'h0, 32'h0, 32'h0, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st3 stall", mem_stall, 1);
      chk("st3 held ctrl", mem_ctrl, C_ST);
      step();
    end
    dmem_ack = 1;
    @(negedge clk);
    chk("st3 ack stall", mem_stall, 0);
    chk("st3 addr", dmem_addr, 32'h20);
    step(); dmem_ack = 0; bubble_ex();
    chk("st3 wb_ctrl", wb_ctrl, C_ST);
    chk("st3 next ctrl", mem_ctrl, C_ALU);
    chk("st3 next fwd", mem_fwd, 32'h777);

    // timeout
    set_ex(C_LD, 32'h100, 32'h0, 32'h0040_0010, 32'h0, 5'd4); step(); bubble_ex();
    run_to_fault(n, seen);
    chk("to fault seen", seen, 1);
    chk("to stall cycles", n, TO);
    chk("to fault_pc", fault_pc, 32'h0040_0010);
    chk("to wb_ctrl", wb_ctrl, 0);
    @(negedge clk);
    chk("to pulse width", mem_fault, 0);
    step();

    // misaligned
    set_ex(C_LD, 32'h42, 32'h0, 32'h500, 32'h0, 5'd6); step(); bubble_ex();
    @(negedge clk);
    chk("mis fault", mem_fault, 1);
    chk("mis req", dmem_req, 0);
    chk("mis stall", mem_stall, 0);
    step();
    chk("mis fault_pc", fault_pc, 32'h500);
    chk("mis wb_ctrl", wb_ctrl, 0);

    // flush in WAIT, then ack
    set_ex(C_ST, 32'h200, 32'h99, 32'h700, 32'h0, 5'd0); step(); bubble_ex();
    @(negedge clk); chk("fl stall", mem_stall, 1);
    step(); flush = 1;
    @(negedge clk); chk("fl req", dmem_req, 1);
    step(); flush = 0; dmem_ack = 1;
    @(negedge clk);
    chk("fl req at ack", dmem_req, 1);
    chk("fl we at ack", dmem_we, 1);
    chk("fl stall at ack", mem_stall, 0);
    step(); dmem_ack = 0;
    chk("fl wb_ctrl", wb_ctrl, 0);

    // halt in WAIT freezes the counter
    set_ex(C_LD, 32'h300, 32'h0, 32'h600, 32'h0, 5'd8); step(); bubble_ex();
    @(negedge clk); chk("ht stall", mem_stall, 1);
    step(); halt = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("ht req held", dmem_req, 1);
      chk("ht no fault", mem_fault, 0);
      step();
    end
    halt = 0;
    run_to_fault(n, seen);
    chk("ht fault seen", seen, 1);
    chk("ht stalls after halt", n, TO - 1);
    chk("ht fault_pc", fault_pc, 32'h600);

    // reset mid-WAIT
    set_ex(C_ALU, 32'h11, 32'h0, 32'h0, 32'h0, 5'd2); step();
    set_ex(C_ST, 32'h400, 32'h1, 32'h0, 32'h0, 5'd0); step(); bubble_ex();
    @(negedge clk);
    chk("rw stall", mem_stall, 1);
    chk("rw wb_ctrl before", wb_ctrl, C_ALU);
    step(); rst_n = 0; step(); rst_n = 1;
    chk("rw req", dmem_req, 0);
    chk("rw stall", mem_stall, 0);
    chk("rw wb_ctrl", wb_ctrl, 0);
    chk("rw mem_ctrl", mem_ctrl, 0);

    // randomized stream against the reference model
    for (int i = 0; i < 8; i++)    model_mem[i] = 32'hA5A5_0000 + i;
    for (int a = 0; a < 1024; a++) resp_mem[a]  = 32'hA5A5_0000 + a;
    do_reset();
    last_ram = 32'h0;
    cur = '{default: 0};
    nxt = gen_instr();
    waited = 0; stalls = 0; faults = 0;
    n = 0;
    while (n < 300) begin
      set_ex(nxt.ctrl, nxt.alu, nxt.din, nxt.pc, nxt.imm, nxt.dst);
      dmem_ack   = dmem_req && (waited == cur.lat);
      dmem_rdata = resp_mem[dmem_addr];
      @(negedge clk);
      st = mem_stall;
      if (mem_fault) faults++;
      if (st) stalls++;
      if (dmem_req && dmem_ack && dmem_we) resp_mem[dmem_addr] = dmem_wdata;
      step();
      if (st) begin
        waited++;
        if (waited > 40) begin
          $display("FAIL rnd stall bound: waited %0d cycles", waited);
          fails++;
          break;
        end
      end else begin
        chk("rnd wb_ctrl", wb_ctrl, cur.exp_wbctrl);
        chk("rnd wb_res", wb_res, cur.exp_res);
        chk("rnd wb_dst", wb_dst, cur.dst);
        chk("rnd wb_ram", wb_ram, cur.exp_ram);
        chk("rnd stalls", stalls, cur.exp_stall);
        chk("rnd faults", faults, cur.exp_fault);
        cur = nxt;
        nxt = gen_instr();
        waited = 0; stalls = 0; faults = 0;
        n++;
      end
    end
    dmem_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
